// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared types and helpers for the register-file write-back unit
package rf_wb_pkg;

  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPLIT_LO = 2'd1,
    SPLIT_HI = 2'd2
  } wb_state_e;

  localparam int CH_LOAD = 0;

endpackage

// File: rtl/rf_wb_rrarb.sv
// rtl/rf_wb_rrarb.sv - round-robin arbiter: search starts at ptr, one-hot grant out
module rf_wb_rrarb #(
  parameter int NSRC = 4,
  parameter int PW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NSRC-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            vld_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NSRC; k++) begin
      cand = (int'(ptr_i) + k) % NSRC;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = PW'(cand);
      end
    end
  end

  assign vld_o = found;

endmodule

// File: rtl/rf_wb_unit.sv
// rtl/rf_wb_unit.sv - arbitrated RF write-back with word splitting and busy scoreboard
// Optional combinational bypass of the write being strobed: RF_WB_BYPASS_EN.
module rf_wb_unit
  import rf_wb_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int DW        = 8,
  parameter int NSRC      = 4,
  parameter int WORD_PORT = 1,
  localparam int AW       = addr_width(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC*2*DW-1:0] src_data,
  input  logic [NSRC-1:0]      src_word,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 iss_word,
  input  logic [AW-1:0]        chk_addr_a,
  input  logic [AW-1:0]        chk_addr_b,
  output logic [1:0]           chk_busy,
  output logic [AW-1:0]        waddr,
  output logic [2*DW-1:0]      wdata,
  output logic                 we_byte,
  output logic                 we_word,
  output logic                 wb_idle
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]        byp_addr_a,
  input  logic [AW-1:0]        byp_addr_b,
  output logic [1:0]           byp_hit,
  output logic [DW-1:0]        byp_data_a,
  output logic [DW-1:0]        byp_data_b
`endif
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  wb_state_e         state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, gnt_idx;
  logic [NSRC-1:0]   gnt;
  logic              gnt_vld, accept_en;
  logic [AW-1:0]     waddr_q, waddr_d, sel_addr;
  logic [2*DW-1:0]   wdata_q, wdata_d, sel_data;
  logic              sel_word;
  logic              we_byte_q, we_byte_d, we_word_q, we_word_d;
  logic [DW-1:0]     hi_q, hi_d;
  logic [NREG-1:0]   busy_q, busy_d, busy_set, busy_clr;

  // New writes only enter while no split beat is pending on the output stage.
  assign accept_en = (state_q == IDLE);

  rf_wb_rrarb #(.NSRC(NSRC), .PW(PW)) u_arb (
    .req_i (src_valid & {NSRC{accept_en}}),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign src_ready = gnt;
  assign sel_addr  = src_addr[gnt_idx*AW +: AW];
  assign sel_data  = src_data[gnt_idx*2*DW +: 2*DW];
  assign sel_word  = src_word[gnt_idx];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    waddr_d   = '0;
    wdata_d   = '0;
    we_byte_d = 1'b0;
    we_word_d = 1'b0;
    hi_d      = hi_q;
    case (state_q)
      SPLIT_LO: begin
        waddr_d   = waddr_q | AW'(1);
        wdata_d   = {{DW{1'b0}}, hi_q};
        we_byte_d = 1'b1;
        state_d   = SPLIT_HI;
      end
      SPLIT_HI: state_d = IDLE;
      default: begin
        if (gnt_vld) begin
          ptr_d = (gnt_idx == PW'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
          if (sel_word) begin
            waddr_d = {sel_addr[AW-1:1], 1'b0};
            if (WORD_PORT != 0) begin
              wdata_d   = sel_data;
              we_word_d = 1'b1;
            end else begin
              wdata_d   = {{DW{1'b0}}, sel_data[DW-1:0]};
              hi_d      = sel_data[2*DW-1:DW];
              we_byte_d = 1'b1;
              state_d   = SPLIT_LO;
            end
          end else begin
            waddr_d   = sel_addr;
            wdata_d   = {{DW{1'b0}}, sel_data[DW-1:0]};
            we_byte_d = 1'b1;
          end
        end
      end
    endcase
  end

  // A split word releases its pair only once the high beat is on the port.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (iss_valid) begin
      if (iss_word) begin
        busy_set[{iss_addr[AW-1:1], 1'b0}] = 1'b1;
        busy_set[{iss_addr[AW-1:1], 1'b1}] = 1'b1;
      end else begin
        busy_set[iss_addr] = 1'b1;
      end
    end
    if (we_word_q || (we_byte_q && state_q == SPLIT_HI)) begin
      busy_clr[{waddr_q[AW-1:1], 1'b0}] = 1'b1;
      busy_clr[{waddr_q[AW-1:1], 1'b1}] = 1'b1;
    end else if (we_byte_q && state_q == IDLE) begin
      busy_clr[waddr_q] = 1'b1;
    end
    busy_d = (busy_q & ~busy_clr) | busy_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_byte_q <= 1'b0;
      we_word_q <= 1'b0;
      hi_q      <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      we_byte_q <= we_byte_d;
      we_word_q <= we_word_d;
      hi_q      <= hi_d;
      busy_q    <= busy_d;
    end
  end

  assign chk_busy = {busy_q[chk_addr_b], busy_q[chk_addr_a]};
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign we_byte  = we_byte_q;
  assign we_word  = we_word_q;
  assign wb_idle  = !we_byte_q && !we_word_q && (state_q == IDLE);

`ifdef RF_WB_BYPASS_EN
  always_comb begin
    byp_hit[0] = (we_byte_q && waddr_q == byp_addr_a) ||
                 (we_word_q && waddr_q[AW-1:1] == byp_addr_a[AW-1:1]);
    byp_hit[1] = (we_byte_q && waddr_q == byp_addr_b) ||
                 (we_word_q && waddr_q[AW-1:1] == byp_addr_b[AW-1:1]);
    byp_data_a = (we_word_q && byp_addr_a[0]) ? wdata_q[2*DW-1:DW] : wdata_q[DW-1:0];
    byp_data_b = (we_word_q && byp_addr_b[0]) ? wdata_q[2*DW-1:DW] : wdata_q[DW-1:0];
  end
`endif

endmodule

// File: tb/tb_rf_wb_unit.sv
// tb/tb_rf_wb_unit.sv - directed bench: split (WORD_PORT=0) and word-port (WORD_PORT=1) instances
module tb_rf_wb_unit;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     src_valid;
  logic [NS*AW-1:0]  src_addr;
  logic [NS*2*DW-1:0] src_data;
  logic [NS-1:0]     src_word;
  logic              iss_valid, iss_word;
  logic [AW-1:0]     iss_addr, chk_addr_a, chk_addr_b;

  logic [NS-1:0]     src_ready, src_ready_w;
  logic [1:0]        chk_busy, chk_busy_w;
  logic [AW-1:0]     waddr, waddr_w;
  logic [2*DW-1:0]   wdata, wdata_w;
  logic              we_byte, we_byte_w, we_word, we_word_w, wb_idle, wb_idle_w;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0]     byp_addr_a, byp_addr_b;
  logic [1:0]        byp_hit, byp_hit_w;
  logic [DW-1:0]     byp_data_a, byp_data_b, byp_data_a_w, byp_data_b_w;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_unit #(.NREG(32), .DW(DW), .NSRC(NS), .WORD_PORT(0)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data), .src_word(src_word),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_word(iss_word),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .chk_busy(chk_busy),
    .waddr(waddr), .wdata(wdata), .we_byte(we_byte), .we_word(we_word), .wb_idle(wb_idle)
`ifdef RF_WB_BYPASS_EN
    , .byp_addr_a(byp_addr_a), .byp_addr_b(byp_addr_b), .byp_hit(byp_hit),
    .byp_data_a(byp_data_a), .byp_data_b(byp_data_b)
`endif
  );

  rf_wb_unit #(.NREG(32), .DW(DW), .NSRC(NS), .WORD_PORT(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready_w),
    .src_addr(src_addr), .src_data(src_data), .src_word(src_word),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_word(iss_word),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b), .chk_busy(chk_busy_w),
    .waddr(waddr_w), .wdata(wdata_w), .we_byte(we_byte_w), .we_word(we_word_w), .wb_idle(wb_idle_w)
`ifdef RF_WB_BYPASS_EN
    , .byp_addr_a(byp_addr_a), .byp_addr_b(byp_addr_b), .byp_hit(byp_hit_w),
    .byp_data_a(byp_data_a_w), .byp_data_b(byp_data_b_w)
`endif
  );

  task automatic set_src(input int ch, input logic [AW-1:0] a, input logic [15:0] d, input logic w);
    src_addr[ch*AW +: AW]   = a;
    src_data[ch*16 +: 16]   = d;
    src_word[ch]            = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0; src_addr = '0; src_data = '0; src_word = '0;
    iss_valid = 1'b0; iss_addr = '0; iss_word = 1'b0;
    chk_addr_a = '0; chk_addr_b = '0;
`ifdef RF_WB_BYPASS_EN
    byp_addr_a = '0; byp_addr_b = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (we_byte !== 1'b0) begin n_err++; $display("FAIL rst_we_byte got=%0h exp=0", we_byte); end
    n_vec++; if (we_word_w !== 1'b0) begin n_err++; $display("FAIL rst_we_word got=%0h exp=0", we_word_w); end
    n_vec++; if (waddr !== 5'd0 || wdata !== 16'h0) begin n_err++; $display("FAIL rst_wport got=%0h/%0h exp=0/0", waddr, wdata); end
    n_vec++; if (wb_idle !== 1'b1 || wb_idle_w !== 1'b1) begin n_err++; $display("FAIL rst_idle got=%0b%0b exp=11", wb_idle, wb_idle_w); end
    n_vec++; if (chk_busy !== 2'b00) begin n_err++; $display("FAIL rst_busy got=%0b exp=00", chk_busy); end
    src_valid = 4'hF;
    #1;
    n_vec++; if (src_ready !== 4'b0001) begin n_err++; $display("FAIL rst_ptr got=%0b exp=0001", src_ready); end
    src_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_byte();
    do_reset();
    set_src(1, 5'd5, 16'h00A3, 1'b0);
    src_valid = 4'b0010;
    #1;
    n_vec++; if (src_ready !== 4'b0010) begin n_err++; $display("FAIL byte_ready got=%0b exp=0010", src_ready); end
    @(posedge clk); #1;
    src_valid = '0;
    n_vec++; if (waddr !== 5'd5) begin n_err++; $display("FAIL byte_waddr got=%0d exp=5", waddr); end
    n_vec++; if (wdata[7:0] !== 8'hA3) begin n_err++; $display("FAIL byte_wdata got=%0h exp=a3", wdata[7:0]); end
    n_vec++; if (we_byte !== 1'b1 || we_word !== 1'b0) begin n_err++; $display("FAIL byte_strobe got=%0b%0b exp=10", we_byte, we_word); end
    n_vec++; if (wb_idle !== 1'b0) begin n_err++; $display("FAIL byte_busyport got=%0b exp=0", wb_idle); end
    n_vec++; if (we_byte_w !== 1'b1 || waddr_w !== 5'd5) begin n_err++; $display("FAIL byte_w got=%0b/%0d exp=1/5", we_byte_w, waddr_w); end
`ifdef RF_WB_BYPASS_EN
    byp_addr_a = 5'd5; byp_addr_b = 5'd6;
    #1;
    n_vec++; if (byp_hit !== 2'b01) begin n_err++; $display("FAIL byp_hit got=%0b exp=01", byp_hit); end
    n_vec++; if (byp_data_a !== 8'hA3) begin n_err++; $display("FAIL byp_data got=%0h exp=a3", byp_data_a); end
`endif
    @(posedge clk); #1;
    n_vec++; if (we_byte !== 1'b0) begin n_err++; $display("FAIL byte_single got=%0b exp=0", we_byte); end
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL byte_idle got=%0b exp=1", wb_idle); end
  endtask

  task automatic test_split();
    do_reset();
    set_src(2, 5'd27, 16'h1234, 1'b1);
    src_valid = 4'b0100;
    #1;
    n_vec++; if (src_ready !== 4'b0100) begin n_err++; $display("FAIL split_acc got=%0b exp=0100", src_ready); end
    @(posedge clk); #1;
    set_src(3, 5'd9, 16'h0055, 1'b0);
    src_valid = 4'b1000;
    n_vec++; if (waddr !== 5'd26 || wdata[7:0] !== 8'h34 || we_byte !== 1'b1 || we_word !== 1'b0) begin
      n_err++; $display("FAIL split_lo got=%0d/%0h/%0b%0b exp=26/34/10", waddr, wdata[7:0], we_byte, we_word); end
    n_vec++; if (we_word_w !== 1'b1 || we_byte_w !== 1'b0 || waddr_w !== 5'd26 || wdata_w !== 16'h1234) begin
      n_err++; $display("FAIL wordport got=%0b%0b/%0d/%0h exp=10/26/1234", we_word_w, we_byte_w, waddr_w, wdata_w); end
`ifdef RF_WB_BYPASS_EN
    byp_addr_a = 5'd26; byp_addr_b = 5'd27;
    #1;
    n_vec++; if (byp_hit_w !== 2'b11 || byp_data_b_w !== 8'h12) begin
      n_err++; $display("FAIL byp_word got=%0b/%0h exp=11/12", byp_hit_w, byp_data_b_w); end
`endif
    #1;
    n_vec++; if (src_ready !== 4'b0000) begin n_err++; $display("FAIL split_lo_ready got=%0b exp=0000", src_ready); end
    @(posedge clk); #1;
    n_vec++; if (waddr !== 5'd27 || wdata[7:0] !== 8'h12 || we_byte !== 1'b1) begin
      n_err++; $display("FAIL split_hi got=%0d/%0h/%0b exp=27/12/1", waddr, wdata[7:0], we_byte); end
    #1;
    n_vec++; if (src_ready !== 4'b0000) begin n_err++; $display("FAIL split_hi_ready got=%0b exp=0000", src_ready); end
    @(posedge clk); #1;
    n_vec++; if (we_byte !== 1'b0) begin n_err++; $display("FAIL split_end got=%0b exp=0", we_byte); end
    #1;
    n_vec++; if (src_ready !== 4'b1000) begin n_err++; $display("FAIL split_resume got=%0b exp=1000", src_ready); end
    @(posedge clk); #1;
    src_valid = '0;
    n_vec++; if (waddr !== 5'd9 || wdata[7:0] !== 8'h55 || we_byte !== 1'b1) begin
      n_err++; $display("FAIL split_next got=%0d/%0h/%0b exp=9/55/1", waddr, wdata[7:0], we_byte); end
  endtask

  task automatic test_round_robin();
    logic [3:0]    exp_g;
    logic [AW-1:0] exp_a;
    do_reset();
    for (int ch = 0; ch < NS; ch++) set_src(ch, AW'(ch + 1), 16'(8'h10 + ch), 1'b0);
    src_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = 4'b0001 << (c % 4);
      n_vec++; if (src_ready !== exp_g) begin n_err++; $display("FAIL rr_grant%0d got=%0b exp=%0b", c, src_ready, exp_g); end
      if (c > 0) begin
        exp_a = AW'((c - 1) % 4 + 1);
        n_vec++; if (waddr !== exp_a || we_byte !== 1'b1) begin
          n_err++; $display("FAIL rr_write%0d got=%0d/%0b exp=%0d/1", c, waddr, we_byte, exp_a); end
      end
      @(posedge clk); #1;
    end
    src_valid = '0;
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_valid = 1'b1; iss_addr = 5'd16; iss_word = 1'b1;
    chk_addr_a = 5'd16; chk_addr_b = 5'd17;
    #1;
    n_vec++; if (chk_busy !== 2'b00) begin n_err++; $display("FAIL sb_pre got=%0b exp=00", chk_busy); end
    @(posedge clk); #1;
    iss_valid = 1'b0;
    n_vec++; if (chk_busy !== 2'b11) begin n_err++; $display("FAIL sb_set got=%0b exp=11", chk_busy); end
    chk_addr_b = 5'd18;
    #1;
    n_vec++; if (chk_busy !== 2'b01) begin n_err++; $display("FAIL sb_other got=%0b exp=01", chk_busy); end
    chk_addr_b = 5'd17;
    set_src(0, 5'd16, 16'hCAFE, 1'b1);
    src_valid = 4'b0001;
    @(posedge clk); #1;
    src_valid = '0;
    n_vec++; if (chk_busy !== 2'b11) begin n_err++; $display("FAIL sb_lo got=%0b exp=11", chk_busy); end
    n_vec++; if (chk_busy_w !== 2'b11) begin n_err++; $display("FAIL sb_w_strobe got=%0b exp=11", chk_busy_w); end
    @(posedge clk); #1;
    n_vec++; if (chk_busy !== 2'b11 || waddr !== 5'd17 || wdata[7:0] !== 8'hCA) begin
      n_err++; $display("FAIL sb_hi got=%0b/%0d/%0h exp=11/17/ca", chk_busy, waddr, wdata[7:0]); end
    n_vec++; if (chk_busy_w !== 2'b00) begin n_err++; $display("FAIL sb_w_clr got=%0b exp=00", chk_busy_w); end
    @(posedge clk); #1;
    n_vec++; if (chk_busy !== 2'b00) begin n_err++; $display("FAIL sb_clr got=%0b exp=00", chk_busy); end
    iss_valid = 1'b1;
    @(posedge clk); #1;
    iss_valid = 1'b0;
    src_valid = 4'b0001;
    @(posedge clk); #1;
    src_valid = '0;
    @(posedge clk); #1;
    iss_valid = 1'b1;
    @(posedge clk); #1;
    iss_valid = 1'b0;
    n_vec++; if (chk_busy !== 2'b11) begin n_err++; $display("FAIL sb_setwins got=%0b exp=11", chk_busy); end
  endtask

  task automatic test_reset_mid_split();
    do_reset();
    set_src(1, 5'd6, 16'hBEEF, 1'b1);
    src_valid = 4'b0010;
    @(posedge clk); #1;
    src_valid = '0;
    n_vec++; if (waddr !== 5'd6 || we_byte !== 1'b1 || wdata[7:0] !== 8'hEF) begin
      n_err++; $display("FAIL abort_lo got=%0d/%0b/%0h exp=6/1/ef", waddr, we_byte, wdata[7:0]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (waddr !== 5'd0 || wdata !== 16'h0 || we_byte !== 1'b0 || we_word !== 1'b0) begin
      n_err++; $display("FAIL abort_out got=%0d/%0h/%0b%0b exp=0/0/00", waddr, wdata, we_byte, we_word); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_vec++; if (wb_idle !== 1'b1) begin n_err++; $display("FAIL abort_idle got=%0b exp=1", wb_idle); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_vec++; if (we_byte !== 1'b0 || waddr === 5'd7) begin
        n_err++; $display("FAIL abort_nohi%0d got=%0b/%0d exp=0/0", c, we_byte, waddr); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte();
    test_split();
    test_round_robin();
    test_scoreboard();
    test_reset_mid_split();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
